// File: rtl/ltl_mon_pkg.sv
// Shared constants and helpers for the LTL monitor report path.
package ltl_mon_pkg;

    localparam int SYMBOL_W      = 8;
    localparam int N_REPORTS_DEF = 4;

    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Single-clock FIFO with wrap-bit pointers, async reset and synchronous flush.
module ltl_report_fifo
    import ltl_mon_pkg::*;
#(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = clog2_depth(DEPTH);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps automaton report cycles, buffers them and drains over valid/ready.
module ltl_report_collector
    import ltl_mon_pkg::*;
#(
    parameter int N_REPORTS = N_REPORTS_DEF,
    parameter int IDX_W     = 32,
    parameter int DEPTH     = 8,
    parameter int DROP_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [SYMBOL_W-1:0]  symbols,
    input  logic [N_REPORTS-1:0] report,
    input  logic                 clear,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [IDX_W-1:0]     ev_idx,
    output logic [N_REPORTS-1:0] ev_report,
    output logic [SYMBOL_W-1:0]  ev_symbol,
    output logic [N_REPORTS-1:0] hit_sticky,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int ENTRY_W = IDX_W + N_REPORTS + SYMBOL_W;

    logic [IDX_W-1:0]   idx;
    logic               ev_in;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    assign ev_in    = run & (|report);
    assign pop      = ev_valid & ev_ready;
    assign drop     = ev_in & full & ~pop;
    assign wr_entry = {idx, report, symbols};
    assign ev_valid = ~empty;
    // Stale storage is masked so the head fields read zero while empty.
    assign {ev_idx, ev_report, ev_symbol} = empty ? '0 : rd_entry;

    ltl_report_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (ev_in),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            hit_sticky <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else if (clear) begin
            idx        <= '0;
            hit_sticky <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (run) begin
                idx        <= idx + IDX_W'(1);
                hit_sticky <= hit_sticky | report;
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench for ltl_report_collector with a queue-based reference model.
module tb_ltl_report_collector;

    localparam int NR    = 4;
    localparam int IW    = 4;
    localparam int DEP   = 8;
    localparam int DW    = 2;
    localparam int DMAX  = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          run;
    logic [7:0]    symbols;
    logic [NR-1:0] report;
    logic          clear;
    logic          ev_valid;
    logic          ev_ready;
    logic [IW-1:0] ev_idx;
    logic [NR-1:0] ev_report;
    logic [7:0]    ev_symbol;
    logic [NR-1:0] hit_sticky;
    logic          overflow;
    logic [DW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    ltl_report_collector #(
        .N_REPORTS (NR),
        .IDX_W     (IW),
        .DEPTH     (DEP),
        .DROP_W    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .symbols    (symbols),
        .report     (report),
        .clear      (clear),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_idx     (ev_idx),
        .ev_report  (ev_report),
        .ev_symbol  (ev_symbol),
        .hit_sticky (hit_sticky),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an event list with pop-before-push space accounting.
    typedef struct {
        int idx;
        int rep;
        int sym;
    } ent_t;

    ent_t q[$];
    int   m_idx;
    int   m_sticky;
    int   m_ovf;
    int   m_drops;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_idx = 0; m_sticky = 0; m_ovf = 0; m_drops = 0;
        end else if (clear) begin
            q.delete();
            m_idx = 0; m_sticky = 0; m_ovf = 0; m_drops = 0;
        end else begin
            if (q.size() > 0 && ev_ready) void'(q.pop_front());
            if (run && report != 0) begin
                if (q.size() < DEP) q.push_back('{m_idx, int'(report), int'(symbols)});
                else begin
                    m_ovf = 1;
                    m_drops++;
                end
            end
            if (run) begin
                m_idx    = (m_idx + 1) % (1 << IW);
                m_sticky = m_sticky | int'(report);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
            chk("ev_idx",    32'(ev_idx),    q.size() > 0 ? 32'(q[0].idx) : 32'd0);
            chk("ev_report", 32'(ev_report), q.size() > 0 ? 32'(q[0].rep) : 32'd0);
            chk("ev_symbol", 32'(ev_symbol), q.size() > 0 ? 32'(q[0].sym) : 32'd0);
            chk("hit_sticky", 32'(hit_sticky), 32'(m_sticky));
            chk("overflow",   32'(overflow),   32'(m_ovf));
            chk("drop_cnt",   32'(drop_cnt),   32'(m_drops > DMAX ? DMAX : m_drops));
        end
    end

    task automatic step(input logic r, input logic [7:0] s, input logic [NR-1:0] rp,
                        input logic rd, input logic cl);
        run = r; symbols = s; report = rp; ev_ready = rd; clear = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 0; symbols = 0; report = 0; clear = 0; ev_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_idx", 32'(ev_idx), 0);
        chk("rst_sticky", 32'(hit_sticky), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Basic: one event on the third run cycle
        for (int i = 0; i < 5; i++) begin
            step(1, 8'(8'h10 + i), (i == 2) ? 4'b0001 : 4'b0000, 1, 0);
            if (i == 2) begin
                chk("basic_valid", 32'(ev_valid), 1);
                chk("basic_idx", 32'(ev_idx), 2);
                chk("basic_rep", 32'(ev_report), 32'h1);
                chk("basic_sym", 32'(ev_symbol), 32'h12);
            end
        end
        chk("basic_empty", 32'(ev_valid), 0);
        chk("basic_sticky", 32'(hit_sticky), 32'h1);
        step(0, 0, 0, 1, 1);
        chk("clr_sticky", 32'(hit_sticky), 0);

        // Backpressure and overflow
        for (int i = 0; i < 10; i++) step(1, 8'(i), 4'b1000, 0, 0);
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_drop", 32'(drop_cnt), 2);
        for (int k = 0; k < 8; k++) begin
            chk("bp_pop_valid", 32'(ev_valid), 1);
            chk("bp_pop_idx", 32'(ev_idx), 32'(k));
            step(0, 0, 0, 1, 0);
        end
        chk("bp_drained", 32'(ev_valid), 0);

        // Full FIFO with simultaneous pop and push
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 4'b1000, 0, 0);
        step(1, 8'hAA, 4'b0100, 1, 0);
        chk("fpp_drop", 32'(drop_cnt), 0);
        chk("fpp_head", 32'(ev_idx), 1);
        step(1, 8'hBB, 4'b0001, 0, 0);
        chk("fpp_still_full", 32'(drop_cnt), 1);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 0);
        chk("fpp_last_idx", 32'(ev_idx), 8);
        chk("fpp_last_rep", 32'(ev_report), 32'h4);
        chk("fpp_last_sym", 32'(ev_symbol), 32'hAA);
        step(0, 0, 0, 1, 0);

        // Drop counter saturation
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 13; i++) step(1, 8'(i), 4'b0010, 0, 0);
        chk("sat_drop", 32'(drop_cnt), DMAX);

        // run gating
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h55, 4'b1111, 1, 0);
            chk("gate_sticky", 32'(hit_sticky), 0);
            chk("gate_valid", 32'(ev_valid), 0);
        end
        step(1, 8'h55, 4'b1111, 1, 0);
        chk("gate_run_sticky", 32'(hit_sticky), 32'hF);
        chk("gate_run_idx", 32'(ev_idx), 0);
        chk("gate_run_valid", 32'(ev_valid), 1);
        step(0, 0, 0, 1, 0);

        // clear with queued events plus a simultaneous event and pop
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 4'b0010, 0, 0);
        step(1, 8'h77, 4'b0001, 1, 1);
        chk("clr_valid", 32'(ev_valid), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        chk("clr_sticky2", 32'(hit_sticky), 0);
        step(1, 8'h01, 4'b0001, 0, 0);
        chk("clr_idx", 32'(ev_idx), 0);

        // Index wrap
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, 8'(i), (i >= 15) ? 4'b0100 : 4'b0000, 0, 0);
        chk("wrap_idx15", 32'(ev_idx), 15);
        step(0, 0, 0, 1, 0);
        chk("wrap_idx0", 32'(ev_idx), 0);
        chk("wrap_sym", 32'(ev_symbol), 16);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 4'b1001, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ev_valid), 0);
        chk("arst_idx", 32'(ev_idx), 0);
        chk("arst_rep", 32'(ev_report), 0);
        chk("arst_sym", 32'(ev_symbol), 0);
        chk("arst_sticky", 32'(hit_sticky), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        run = 0; report = 0; ev_ready = 0; clear = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 8'h99, 4'b0001, 0, 0);
        chk("post_rst_idx", 32'(ev_idx), 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
